// File: rtl/audio_sample_fifo_pkg.sv
// Shared types and constants for the audio sample FIFO: stream state, sample
// layout and a helper that builds a stereo sample from its two channels.
package audio_sample_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } fifo_state_t;

    localparam int SAMPLE_W = 32;
    localparam int CH_W     = 16;
    localparam int L_LSB    = 16;
    localparam int R_LSB    = 0;

    function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [CH_W-1:0] left,
                                                        input logic [CH_W-1:0] right);
        logic [SAMPLE_W-1:0] s;
        s = '0;
        s[L_LSB +: CH_W] = left;
        s[R_LSB +: CH_W] = right;
        return s;
    endfunction

endpackage

// File: rtl/audio_sample_fifo_if.sv
// Bus between the op decoder / I2S sender (master) and the audio sample FIFO (slave).
interface audio_sample_fifo_if
    import audio_sample_fifo_pkg::*;
#(
    parameter int AW = 4
);

    logic                start;
    logic                stop;
    logic                wr_valid;
    logic [SAMPLE_W-1:0] wr_data;
    logic                rd_ready;
    logic                rd_valid;
    logic [SAMPLE_W-1:0] rd_data;
    logic [AW:0]         count;
    logic                request_mode;
    logic                request_tick;
    logic                overflow;
    logic                underflow;
    logic                active;

    modport master (
        output start, stop, wr_valid, wr_data, rd_ready,
        input  rd_valid, rd_data, count, request_mode, request_tick,
               overflow, underflow, active
    );

    modport slave (
        input  start, stop, wr_valid, wr_data, rd_ready,
        output rd_valid, rd_data, count, request_mode, request_tick,
               overflow, underflow, active
    );

endinterface

// File: rtl/audio_sample_fifo_request_ticker.sv
// Turns a level request into a one-cycle tick on the rising edge and then every
// REQ_PERIOD cycles while the level stays high.
module audio_sample_fifo_request_ticker #(
    parameter int REQ_PERIOD = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic request_mode,
    output logic request_tick
);

    localparam int CW = (REQ_PERIOD > 1) ? $clog2(REQ_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(REQ_PERIOD - 1);

    logic          mode_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_d       <= 1'b0;
            cnt          <= '0;
            request_tick <= 1'b0;
        end else begin
            mode_d <= request_mode;
            if (!request_mode) begin
                cnt          <= '0;
                request_tick <= 1'b0;
            end else if (!mode_d) begin
                cnt          <= '0;
                request_tick <= 1'b1;
            end else if (cnt == LAST) begin
                cnt          <= '0;
                request_tick <= 1'b1;
            end else begin
                cnt          <= cnt + 1'b1;
                request_tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/audio_sample_fifo.sv
// Elastic buffer for stereo samples between the op decoder and the I2S sender,
// with prime/run/drain stream control and host request generation.
module audio_sample_fifo
    import audio_sample_fifo_pkg::*;
#(
    parameter int AW          = 4,
    parameter int START_LEVEL = 8,
    parameter int LOW_WM      = 4,
    parameter int HIGH_WM     = 12,
    parameter int REQ_PERIOD  = 256
) (
    input  logic               mon_clk,
    input  logic               reset,
    audio_sample_fifo_if.slave bus
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] START_C = (AW+1)'(START_LEVEL);
    localparam logic [AW:0] LOW_C   = (AW+1)'(LOW_WM);
    localparam logic [AW:0] HIGH_C  = (AW+1)'(HIGH_WM);

    fifo_state_t state, state_next;

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count_q, count_next;

    logic flush, accepts, full, rd_valid_c, push, pop;
    logic req_q, req_next;
    logic ovf_q, ovf_next;
    logic unf_q, unf_next;
    logic active_q;
    logic tick;

    always_ff @(posedge mon_clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // start restarts the stream from any state and overrides stop and any write
    // in the same cycle; transitions look at next-cycle occupancy so the stream
    // reacts in the cycle right after the write/pop that crosses a level.
    always_comb begin
        flush      = bus.start;
        accepts    = (state == ST_PRIME) || (state == ST_RUN);
        full       = (count_q == FULL_C);
        rd_valid_c = ((state == ST_RUN) || (state == ST_DRAIN)) && (count_q != '0);
        pop        = bus.rd_ready && rd_valid_c && !flush;
        push       = bus.wr_valid && accepts && (!full || pop) && !flush;

        count_next = count_q;
        if (flush)              count_next = '0;
        else if (push && !pop)  count_next = count_q + 1'b1;
        else if (pop && !push)  count_next = count_q - 1'b1;

        state_next = state;
        if (bus.start) begin
            state_next = ST_PRIME;
        end else begin
            case (state)
                ST_PRIME: begin
                    if (bus.stop)                    state_next = ST_DRAIN;
                    else if (count_next >= START_C)  state_next = ST_RUN;
                end
                ST_RUN:   if (bus.stop)              state_next = ST_DRAIN;
                ST_DRAIN: if (count_next == '0)      state_next = ST_IDLE;
                default:  state_next = state;
            endcase
        end

        req_next = 1'b0;
        case (state_next)
            ST_PRIME: req_next = 1'b1;
            ST_RUN: begin
                if (count_next <= LOW_C)       req_next = 1'b1;
                else if (count_next >= HIGH_C) req_next = 1'b0;
                else                           req_next = req_q;
            end
            default:  req_next = 1'b0;
        endcase

        ovf_next = bus.wr_valid && accepts && full && !pop && !flush;
        unf_next = bus.rd_ready && (state == ST_RUN) && (count_q == '0);
    end

    always_ff @(posedge mon_clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge mon_clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            req_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count_q  <= count_next;
            req_q    <= req_next;
            ovf_q    <= ovf_next;
            unf_q    <= unf_next;
            active_q <= (state_next != ST_IDLE);
        end
    end

    audio_sample_fifo_request_ticker #(
        .REQ_PERIOD (REQ_PERIOD)
    ) u_ticker (
        .clk          (mon_clk),
        .rst          (reset),
        .request_mode (req_q),
        .request_tick (tick)
    );

    // Gating keeps rd_data at zero whenever no sample is presented.
    assign bus.rd_valid     = rd_valid_c;
    assign bus.rd_data      = rd_valid_c ? mem[rd_ptr] : '0;
    assign bus.count        = count_q;
    assign bus.request_mode = req_q;
    assign bus.request_tick = tick;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
    assign bus.active       = active_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: priming, hysteresis, full/wrap,
// underflow, drain, restart and mid-stream reset.
module tb_audio_sample_fifo;
    import audio_sample_fifo_pkg::*;

    logic mon_clk;
    logic reset;
    int   checks;
    int   errors;

    audio_sample_fifo_if #(.AW(4)) bus ();

    audio_sample_fifo #(
        .AW          (4),
        .START_LEVEL (8),
        .LOW_WM      (4),
        .HIGH_WM     (12),
        .REQ_PERIOD  (256)
    ) dut (
        .mon_clk (mon_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial mon_clk = 1'b0;
    always #5 mon_clk = ~mon_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge mon_clk);
        #1;
    endtask

    task automatic write(input logic [31:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic pop();
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rd_valid"},     32'(bus.rd_valid),     32'd0);
        check({tag, ".rd_data"},      bus.rd_data,           32'd0);
        check({tag, ".count"},        32'(bus.count),        32'd0);
        check({tag, ".request_mode"}, 32'(bus.request_mode), 32'd0);
        check({tag, ".request_tick"}, 32'(bus.request_tick), 32'd0);
        check({tag, ".overflow"},     32'(bus.overflow),     32'd0);
        check({tag, ".underflow"},    32'(bus.underflow),    32'd0);
        check({tag, ".active"},       32'(bus.active),       32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        step();
        step();
        check_all_zero("por");
        reset = 1'b0;
        step();

        // Prime: one write every three cycles, RUN on the 8th
        pulse_start();
        check("prime.active", 32'(bus.active), 32'd1);
        check("prime.req", 32'(bus.request_mode), 32'd1);
        check("prime.tick0", 32'(bus.request_tick), 32'd0);
        step();
        check("prime.tick1", 32'(bus.request_tick), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            write(pack_sample(16'(i), 16'(i)));
            if (i < 8) begin
                check("prime.rd_valid", 32'(bus.rd_valid), 32'd0);
                check("prime.req_hold", 32'(bus.request_mode), 32'd1);
                step();
                step();
            end
        end
        check("prime.run_valid", 32'(bus.rd_valid), 32'd1);
        check("prime.head", bus.rd_data, 32'h0001_0001);
        check("prime.count8", 32'(bus.count), 32'd8);
        check("prime.req_run", 32'(bus.request_mode), 32'd1);

        // Hysteresis
        for (int i = 9; i <= 12; i++) begin
            write(pack_sample(16'(i), 16'(i)));
            if (i == 11) check("hyst.req11", 32'(bus.request_mode), 32'd1);
        end
        check("hyst.count12", 32'(bus.count), 32'd12);
        check("hyst.req12", 32'(bus.request_mode), 32'd0);
        for (int i = 0; i < 7; i++) pop();
        check("hyst.count5", 32'(bus.count), 32'd5);
        check("hyst.req5", 32'(bus.request_mode), 32'd0);
        check("hyst.head8", bus.rd_data, 32'h0008_0008);
        pop();
        check("hyst.count4", 32'(bus.count), 32'd4);
        check("hyst.req4", 32'(bus.request_mode), 32'd1);
        check("hyst.tick_same", 32'(bus.request_tick), 32'd0);
        step();
        check("hyst.tick_first", 32'(bus.request_tick), 32'd1);
        for (int i = 0; i < 255; i++) step();
        check("hyst.tick_255", 32'(bus.request_tick), 32'd0);
        step();
        check("hyst.tick_256", 32'(bus.request_tick), 32'd1);
        check("hyst.head9", bus.rd_data, 32'h0009_0009);

        // Full, overflow, push+pop at full, wrap ordering
        for (int i = 13; i <= 24; i++) write(pack_sample(16'(i), 16'(i)));
        check("full.count16", 32'(bus.count), 32'd16);
        check("full.req", 32'(bus.request_mode), 32'd0);
        check("full.no_ovf", 32'(bus.overflow), 32'd0);
        write(32'hDEAD_BEEF);
        check("full.ovf", 32'(bus.overflow), 32'd1);
        check("full.count_hold", 32'(bus.count), 32'd16);
        step();
        check("full.ovf_once", 32'(bus.overflow), 32'd0);
        check("full.head9", bus.rd_data, 32'h0009_0009);
        bus.rd_ready = 1'b1;
        write(pack_sample(16'd25, 16'd25));
        bus.rd_ready = 1'b0;
        check("full.pp_count", 32'(bus.count), 32'd16);
        check("full.pp_no_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 10; i <= 25; i++) begin
            check("wrap.order", bus.rd_data, pack_sample(16'(i), 16'(i)));
            pop();
        end
        check("wrap.empty_count", 32'(bus.count), 32'd0);
        check("wrap.empty_valid", 32'(bus.rd_valid), 32'd0);

        // Underflow then drain
        pop();
        check("unf.pulse", 32'(bus.underflow), 32'd1);
        step();
        check("unf.once", 32'(bus.underflow), 32'd0);
        write(32'h1111_2222);
        write(32'h3333_4444);
        write(32'h5555_6666);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("drain.active", 32'(bus.active), 32'd1);
        check("drain.req", 32'(bus.request_mode), 32'd0);
        write(32'h7777_8888);
        check("drain.ignored", 32'(bus.count), 32'd3);
        check("drain.no_ovf", 32'(bus.overflow), 32'd0);
        check("drain.s0", bus.rd_data, 32'h1111_2222);
        pop();
        check("drain.s1", bus.rd_data, 32'h3333_4444);
        pop();
        check("drain.s2", bus.rd_data, 32'h5555_6666);
        check("drain.active2", 32'(bus.active), 32'd1);
        pop();
        check("drain.count0", 32'(bus.count), 32'd0);
        check("drain.idle", 32'(bus.active), 32'd0);
        check("drain.valid0", 32'(bus.rd_valid), 32'd0);

        // Restart during RUN with six samples held
        pulse_start();
        for (int i = 1; i <= 8; i++) write(pack_sample(16'(i), 16'(i)));
        pop();
        pop();
        check("rst.count6", 32'(bus.count), 32'd6);
        check("rst.head3", bus.rd_data, 32'h0003_0003);
        bus.start = 1'b1;
        write(32'hAAAA_5555);
        bus.start = 1'b0;
        check("restart.count", 32'(bus.count), 32'd0);
        check("restart.valid", 32'(bus.rd_valid), 32'd0);
        check("restart.active", 32'(bus.active), 32'd1);
        check("restart.req", 32'(bus.request_mode), 32'd1);
        write(32'h0101_0202);
        check("restart.count1", 32'(bus.count), 32'd1);
        check("restart.prime", 32'(bus.rd_valid), 32'd0);

        // Reset mid-stream with five samples held in RUN
        for (int i = 0; i < 7; i++) write(32'h0505_0000 + 32'(i));
        pop();
        pop();
        pop();
        check("mid.count5", 32'(bus.count), 32'd5);
        check("mid.valid", 32'(bus.rd_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        step();
        reset = 1'b0;
        write(32'h1234_5678);
        check("post.ignored", 32'(bus.count), 32'd0);
        check("post.inactive", 32'(bus.active), 32'd0);
        pulse_start();
        check("post.start_active", 32'(bus.active), 32'd1);
        check("post.start_count", 32'(bus.count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
- Elastic buffer between the op decoder and the I2S sender. Holds 32-bit stereo audio samples received from the NeXT monitor link.
- Decouples packet arrival from the sample rate of the DAC.
- Produces the audio-sample request mode and request tick consumed by the link sender.
- Flow: the stream starts on the audio-start opcode, primes the buffer, plays, and then drains on end-of-audio.

Parameters:
- AW, 4: address width; FIFO depth is 2**AW = 16 entries.
- START_LEVEL, 8: fill level required before playback begins (PRIME -> RUN).
- LOW_WM, 4: at or below this count, request mode asserts.
- HIGH_WM, 12: at or above this count, request mode deasserts. Must satisfy LOW_WM < HIGH_WM <= 2**AW.
- REQ_PERIOD, 256: mon_clk cycles between request ticks while request mode is active.

Ports:
- mon_clk  in  1  system clock; monitor-link clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: audio stream start (audio_starts).
- stop  in  1  one-cycle pulse: end of audio stream (end_audio_sample).
- wr_valid  in  1  one-cycle pulse: sample present on wr_data (is_audio_sample).
- wr_data  in  32  sample; [31:16] left, [15:0] right.
- rd_ready  in  1  I2S sender pops one sample this cycle.
- rd_valid  out  1  rd_data holds a valid sample.
- rd_data  out  32  head-of-FIFO sample, show-ahead.
- count  out  AW+1  current occupancy, range 0..2**AW.
- request_mode  out  1  ask host for more samples.
- request_tick  out  1  one-cycle request pulse.
- overflow  out  1  one-cycle pulse: a write was dropped because the FIFO was full.
- underflow  out  1  one-cycle pulse: rd_ready arrived while empty in RUN.
- active  out  1  high in PRIME, RUN and DRAIN.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; pointers = 0; count = 0.
  - All outputs 0. rd_data is don't-care but 0 in simulation.
- States:
  - IDLE: writes ignored; rd_valid = 0. start -> PRIME.
  - PRIME: writes accepted; rd_valid = 0; request_mode forced 1. count >= START_LEVEL -> RUN. stop -> DRAIN.
  - RUN: rd_valid = (count != 0). stop -> DRAIN.
  - DRAIN: writes ignored; rd_valid = (count != 0). count == 0 -> IDLE.
  - start in RUN or DRAIN: flush pointers and count, go to PRIME. A write in that same cycle is dropped.
  - start and stop in the same cycle: start wins.
- Storage and pointers:
  - Storage is 2**AW x 32.
  - Write pointer wraps modulo 2**AW; read pointer likewise.
  - Write is accepted when wr_valid, the state accepts writes, and (count < 2**AW, or a pop occurs in the same cycle).
- Pop and rd_data:
  - Pop = rd_ready & rd_valid.
  - rd_data = mem[rd_ptr], combinational from the registered pointer. It is valid in the same cycle rd_valid is high.
  - rd_ready with rd_valid low has no effect on the pointers.
- Write-to-read latency: a sample written into an empty FIFO in RUN is visible on rd_data/rd_valid on the next cycle. There is no same-cycle bypass.
- count: +1 on accepted write only, -1 on pop only, unchanged on both or neither.
- overflow: pulses the cycle after a wr_valid is rejected for fullness in PRIME/RUN. It does not pulse for writes ignored in IDLE or DRAIN.
- underflow: pulses the cycle after rd_ready while in RUN with count == 0.
- request_mode (registered):
  - PRIME: 1.
  - RUN: set when count <= LOW_WM; clear when count >= HIGH_WM; otherwise hold (hysteresis).
  - IDLE and DRAIN: 0.
- request_tick (registered):
  - Pulses the cycle after request_mode rises.
  - Then pulses every REQ_PERIOD cycles while request_mode stays high.
  - The period counter resets when request_mode falls.
- active: registered decode of state.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, PRIME, RUN, DRAIN);
  - the sample width constant 32;
  - the L/R field offsets.
- One natural sub-module: request_ticker. It takes request_mode and produces request_tick through the REQ_PERIOD counter, and it is reusable for the keyboard poll path.
- Storage is inferred inside the main module; no separate RAM sub-module.

Test Plan:
- Reset mid-stream: with count = 5 in RUN, assert reset -> all outputs 0 immediately and state IDLE; after release, wr_valid is ignored until start.
- Prime: start, then write samples 0x00010001..0x00080008 one per 3 cycles -> rd_valid stays 0 through 7 samples. It rises the cycle after the 8th write, with rd_data = 0x00010001. request_mode = 1 throughout.
- Hysteresis:
  - In RUN, fill to 12 -> request_mode falls.
  - Pop down to 5 -> request_mode stays 0.
  - Pop to 4 -> request_mode rises, request_tick pulses next cycle and again 256 cycles later.
- Full and wrap: write 16 samples, then a 17th -> overflow pulses once and count stays 16. A simultaneous push+pop at full -> count stays 16, no overflow, and data order is preserved across the pointer wrap.
- Underflow and drain:
  - In RUN, pop all, then assert rd_ready -> underflow pulses once.
  - Write 3 samples, then stop -> the 3 samples are still delivered in order, further writes are ignored, and the block returns to IDLE with active = 0 after the last pop.
- Restart: start during RUN with count = 6 -> count = 0, state PRIME, rd_valid = 0 on the next cycle.
